conv_frame_ctrl: RTL and testbench

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_frame_ctrl.sv | 137 +++++++++++++
 tb/tb_conv_frame_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame controller: FSM state encoding
// and the default derivations of the flush length and expected output count.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } conv_state_t;

    // A 3x3 window needs one full line plus two pixels of trailing zeros to drain.
    function automatic int flush_px_default(input int img_w);
        return img_w + 2;
    endfunction

    function automatic int exp_out_default(input int img_w, input int img_h);
        return (img_w - 2) * (img_h - 2);
    endfunction

endpackage

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a 3x3 convolution: feeds a frame of pixels, flushes the
// window with zeros, then waits for the expected number of results.
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 960,
    parameter int PIX_W    = 8,
    parameter int FLUSH_PX = flush_px_default(IMG_W),
    parameter int EXP_OUT  = exp_out_default(IMG_W, IMG_H),
    parameter int DRAIN_TO = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_px,
    output logic             src_ready,
    output logic             conv_valid_in,
    output logic [PIX_W-1:0] conv_px_in,
    input  logic             conv_valid_out,
    input  logic             fifo_almost_full,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_overflow,
    output logic [31:0]      in_count,
    output logic [31:0]      out_count,
    output logic [31:0]      cycle_count
);

    localparam logic [31:0] LAST_PX    = 32'(IMG_W * IMG_H - 1);
    localparam logic [31:0] FLUSH_LAST = 32'(FLUSH_PX - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_TO - 1);
    localparam logic [31:0] EXP_CNT    = 32'(EXP_OUT);

    conv_state_t state, state_next;

    logic [31:0] flush_cnt;
    logic [31:0] drain_cnt;
    logic [31:0] out_count_nxt;
    logic        accept;
    logic        inject;
    logic        out_inc;
    logic        clear;
    logic        drain_expired;

    assign busy      = (state == FEED) || (state == FLUSH) || (state == DRAIN);
    assign src_ready = (state == FEED) && !fifo_almost_full;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Abort overrides every transition and suppresses all side effects of the cycle.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        inject        = 1'b0;
        clear         = 1'b0;
        drain_expired = 1'b0;
        out_inc       = busy && conv_valid_out && !abort;
        out_count_nxt = out_count + {31'b0, out_inc};
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = FEED;
                    clear      = 1'b1;
                end
            end
            FEED: begin
                accept = src_valid && !fifo_almost_full;
                if (accept && in_count == LAST_PX) state_next = FLUSH;
            end
            FLUSH: begin
                inject = !fifo_almost_full;
                if (inject && flush_cnt == FLUSH_LAST) state_next = DRAIN;
            end
            DRAIN: begin
                if (out_count_nxt == EXP_CNT) begin
                    state_next = DONE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_next    = DONE;
                    drain_expired = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next    = IDLE;
            accept        = 1'b0;
            inject        = 1'b0;
            clear         = 1'b0;
            drain_expired = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            conv_valid_in <= 1'b0;
            conv_px_in    <= '0;
            done          <= 1'b0;
            err_timeout   <= 1'b0;
            err_overflow  <= 1'b0;
            in_count      <= '0;
            out_count     <= '0;
            cycle_count   <= '0;
            flush_cnt     <= '0;
            drain_cnt     <= '0;
        end else begin
            conv_valid_in <= accept || inject;
            done          <= (state_next == DONE);
            if (accept)      conv_px_in <= src_px;
            else if (inject) conv_px_in <= '0;
            if (clear) begin
                err_timeout  <= 1'b0;
                err_overflow <= 1'b0;
                in_count     <= '0;
                out_count    <= '0;
                cycle_count  <= '0;
                flush_cnt    <= '0;
                drain_cnt    <= '0;
            end else begin
                if (accept)                          in_count    <= in_count + 32'd1;
                if (out_inc)                         out_count   <= out_count_nxt;
                if (out_inc && out_count_nxt > EXP_CNT) err_overflow <= 1'b1;
                if (busy && !abort)                  cycle_count <= cycle_count + 32'd1;
                if (inject)                          flush_cnt   <= flush_cnt + 32'd1;
                if (state == DRAIN && !abort)        drain_cnt   <= drain_cnt + 32'd1;
                if (drain_expired)                   err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed self-checking bench for conv_frame_ctrl on a 4x4 frame with a short
// drain timeout; every expected value below is worked out by hand.
module tb_conv_frame_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        src_valid = 1'b0;
    logic [7:0]  src_px = 8'h00;
    logic        src_ready;
    logic        conv_valid_in;
    logic [7:0]  conv_px_in;
    logic        conv_valid_out = 1'b0;
    logic        fifo_almost_full = 1'b0;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_overflow;
    logic [31:0] in_count;
    logic [31:0] out_count;
    logic [31:0] cycle_count;

    int vectors = 0;
    int miscompares = 0;
    int cvi_cnt = 0;
    logic [7:0] px;

    conv_frame_ctrl #(
        .IMG_W(4), .IMG_H(4), .PIX_W(8), .FLUSH_PX(6), .EXP_OUT(4), .DRAIN_TO(8)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .src_valid(src_valid), .src_px(src_px), .src_ready(src_ready),
        .conv_valid_in(conv_valid_in), .conv_px_in(conv_px_in),
        .conv_valid_out(conv_valid_out), .fifo_almost_full(fifo_almost_full),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_overflow(err_overflow),
        .in_count(in_count), .out_count(out_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic setInputs(input logic s, input logic a, input logic v,
                             input logic [7:0] p, input logic f, input logic o);
        start = s; abort = a; src_valid = v; src_px = p;
        fifo_almost_full = f; conv_valid_out = o;
    endtask

    // One clock with the given inputs; outputs are then looked at 1ns after the edge.
    task automatic applyStimulus(input logic s, input logic a, input logic v,
                                 input logic [7:0] p, input logic f, input logic o);
        setInputs(s, a, v, p, f, o);
        @(posedge clk);
        #1;
        if (conv_valid_in) cvi_cnt++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feedPixels(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 8'(16 + i), 0, 0);
    endtask

    task automatic idleCycles(input int n, input logic o);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00, 0, o);
    endtask

    initial begin
        // reset state
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        rstn = 1'b1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_ready", 32'(src_ready), 0);
        checkOutput("rst_cvi", 32'(conv_valid_in), 0);
        checkOutput("rst_in_count", in_count, 0);
        checkOutput("rst_cycle_count", cycle_count, 0);

        // nominal frame: 16 pixels, 6 flush zeros, 4 results in DRAIN
        $display("[TB] nominal frame");
        cvi_cnt = 0;
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        checkOutput("050_busy", 32'(busy), 1);
        checkOutput("050_ready", 32'(src_ready), 1);
        for (int i = 0; i < 16; i++) begin
            px = 8'(16 + i);
            applyStimulus(0, 0, 1, px, 0, 0);
            checkOutput("050_px", 32'(conv_px_in), 32'(px));
            checkOutput("050_in_count", in_count, 32'(i + 1));
        end
        checkOutput("050_ready_flush", 32'(src_ready), 0);
        idleCycles(6, 0);
        checkOutput("050_flush_px", 32'(conv_px_in), 0);
        checkOutput("050_cvi_last_flush", 32'(conv_valid_in), 1);
        idleCycles(3, 1);
        checkOutput("050_drain_busy", 32'(busy), 1);
        idleCycles(1, 1);
        checkOutput("050_done", 32'(done), 1);
        checkOutput("050_busy_end", 32'(busy), 0);
        checkOutput("050_cvi_cycles", 32'(cvi_cnt), 22);
        checkOutput("050_out_count", out_count, 4);
        checkOutput("050_cycle_count", cycle_count, 26);
        checkOutput("050_err_to", 32'(err_timeout), 0);
        checkOutput("050_err_ov", 32'(err_overflow), 0);
        idleCycles(1, 1);
        checkOutput("050_done_ignore_out", out_count, 4);
        checkOutput("050_done_held", 32'(done), 1);
        checkOutput("050_cvi_idle", 32'(conv_valid_in), 0);

        // backpressure for three cycles mid-feed
        $display("[TB] backpressure frame");
        cvi_cnt = 0;
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        checkOutput("051_clear_in", in_count, 0);
        checkOutput("051_clear_out", out_count, 0);
        checkOutput("051_clear_done", 32'(done), 0);
        feedPixels(5);
        for (int i = 0; i < 3; i++) begin
            setInputs(0, 0, 1, 8'hEE, 1, 0);
            #1;
            checkOutput("051_ready_stall", 32'(src_ready), 0);
            applyStimulus(0, 0, 1, 8'hEE, 1, 0);
            checkOutput("051_in_frozen", in_count, 5);
            checkOutput("051_cvi_stall", 32'(conv_valid_in), 0);
            checkOutput("051_px_hold", 32'(conv_px_in), 32'h14);
        end
        feedPixels(11);
        idleCycles(6, 0);
        idleCycles(4, 1);
        checkOutput("051_done", 32'(done), 1);
        checkOutput("051_in_count", in_count, 16);
        checkOutput("051_out_count", out_count, 4);
        checkOutput("051_cvi_cycles", 32'(cvi_cnt), 22);
        checkOutput("051_cycle_count", cycle_count, 29);

        // drain timeout with only two results
        $display("[TB] drain timeout frame");
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        feedPixels(16);
        idleCycles(6, 0);
        idleCycles(2, 1);
        idleCycles(5, 0);
        checkOutput("052_not_done_7", 32'(done), 0);
        checkOutput("052_busy_7", 32'(busy), 1);
        idleCycles(1, 0);
        checkOutput("052_done_8", 32'(done), 1);
        checkOutput("052_err_to", 32'(err_timeout), 1);
        checkOutput("052_err_ov", 32'(err_overflow), 0);
        checkOutput("052_out_count", out_count, 2);

        // overflow: four results during flush, a fifth in DRAIN
        $display("[TB] overflow frame");
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        checkOutput("053_clear_err_to", 32'(err_timeout), 0);
        feedPixels(16);
        idleCycles(4, 1);
        idleCycles(2, 0);
        checkOutput("053_ov_before", 32'(err_overflow), 0);
        checkOutput("053_out_4", out_count, 4);
        idleCycles(1, 1);
        checkOutput("053_ov_on_5th", 32'(err_overflow), 1);
        checkOutput("053_out_5", out_count, 5);
        for (int i = 0; i < 20 && !done; i++) idleCycles(1, 0);
        checkOutput("053_done", 32'(done), 1);
        checkOutput("053_ov_held", 32'(err_overflow), 1);

        // reset from DONE clears sticky flags
        rstn = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        rstn = 1'b1;
        checkOutput("rst2_err_ov", 32'(err_overflow), 0);
        checkOutput("rst2_err_to", 32'(err_timeout), 0);
        checkOutput("rst2_done", 32'(done), 0);
        checkOutput("rst2_out_count", out_count, 0);

        // abort together with start at in_count=7
        $display("[TB] abort frame");
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        feedPixels(7);
        checkOutput("054_in_7", in_count, 7);
        applyStimulus(1, 1, 0, 8'h00, 0, 0);
        checkOutput("054_busy", 32'(busy), 0);
        checkOutput("054_in_hold", in_count, 7);
        checkOutput("054_cvi", 32'(conv_valid_in), 0);
        checkOutput("054_done", 32'(done), 0);
        checkOutput("054_ready", 32'(src_ready), 0);
        applyStimulus(0, 0, 1, 8'h55, 0, 0);
        checkOutput("054_idle_in_hold", in_count, 7);
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        checkOutput("054_restart_in", in_count, 0);
        checkOutput("054_restart_cycles", cycle_count, 0);
        checkOutput("054_restart_busy", 32'(busy), 1);

        // reset in the middle of FLUSH
        $display("[TB] reset during flush");
        feedPixels(16);
        idleCycles(3, 1);
        checkOutput("055_pre_busy", 32'(busy), 1);
        checkOutput("055_pre_in", in_count, 16);
        rstn = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("055_busy", 32'(busy), 0);
        checkOutput("055_cvi", 32'(conv_valid_in), 0);
        checkOutput("055_px", 32'(conv_px_in), 0);
        checkOutput("055_in", in_count, 0);
        checkOutput("055_out", out_count, 0);
        checkOutput("055_cycles", cycle_count, 0);
        checkOutput("055_done", 32'(done), 0);
        rstn = 1'b1;
        applyStimulus(0, 0, 1, 8'h33, 0, 0);
        checkOutput("055_idle_after", 32'(busy), 0);
        checkOutput("055_idle_ready", 32'(src_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
